// File: rtl/gate_ctrl.sv
// Gate-window sequencer for a frequency/period counter: clears the counter,
// opens a timed (frequency) or edge-bounded (period) window, then latches.
module gate_ctrl #(
  parameter int unsigned F_GATE0   = 50_000,
  parameter int unsigned F_GATE1   = 500_000,
  parameter int unsigned F_GATE2   = 5_000_000,
  parameter int unsigned F_GATE3   = 50_000_000,
  parameter int unsigned T_TIMEOUT = 100_000_000
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic       start,
  input  logic       measure_mode,
  input  logic [1:0] F_sel,
  input  logic [1:0] T_sel,
  input  logic       sig_rise,
  output logic       cnt_clr,
  output logic       gate_en,
  output logic       latch,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       cfg_err,
  output logic [6:0] clk_wait
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_GATE  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [26:0] LOAD0    = 27'(F_GATE0 - 1);
  localparam logic [26:0] LOAD1    = 27'(F_GATE1 - 1);
  localparam logic [26:0] LOAD2    = 27'(F_GATE2 - 1);
  localparam logic [26:0] LOAD3    = 27'(F_GATE3 - 1);
  localparam logic [26:0] TMO_LAST = 27'(T_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic        mode_q, mode_d;
  logic [1:0]  fsel_q, fsel_d;
  logic [1:0]  tsel_q, tsel_d;
  logic [26:0] gate_cnt_q, gate_cnt_d;
  logic [6:0]  edge_cnt_q, edge_cnt_d;
  logic [26:0] tmo_cnt_q, tmo_cnt_d;
  logic [6:0]  clk_wait_q, clk_wait_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        gate_en_q, gate_en_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        cfg_err_q, cfg_err_d;

  logic [6:0]  edge_last;
  logic [26:0] gate_load;
  logic        tmo_hit;

  always_comb begin
    case (tsel_q)
      2'b00:   edge_last = 7'd0;
      2'b01:   edge_last = 7'd9;
      default: edge_last = 7'd99;
    endcase
    case (fsel_q)
      2'b00:   gate_load = LOAD0;
      2'b01:   gate_load = LOAD1;
      2'b10:   gate_load = LOAD2;
      default: gate_load = LOAD3;
    endcase
    tmo_hit = (tmo_cnt_q == TMO_LAST);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fsel_d     = fsel_q;
    tsel_d     = tsel_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    clk_wait_d = clk_wait_q;
    cfg_err_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (measure_mode && (T_sel == 2'b11)) begin
            cfg_err_d = 1'b1;
          end else begin
            mode_d  = measure_mode;
            fsel_d  = F_sel;
            tsel_d  = T_sel;
            state_d = S_CLEAR;
            if (measure_mode) begin
              case (T_sel)
                2'b00:   clk_wait_d = 7'b0010000;
                2'b01:   clk_wait_d = 7'b0100000;
                default: clk_wait_d = 7'b1000000;
              endcase
            end else begin
              case (F_sel)
                2'b00:   clk_wait_d = 7'b0000001;
                2'b01:   clk_wait_d = 7'b0000010;
                2'b10:   clk_wait_d = 7'b0000100;
                default: clk_wait_d = 7'b0001000;
              endcase
            end
          end
        end
      end
      S_CLEAR: begin
        tmo_cnt_d  = '0;
        edge_cnt_d = '0;
        gate_cnt_d = gate_load;
        state_d    = mode_q ? S_ARM : S_GATE;
      end
      S_ARM: begin
        tmo_cnt_d = tmo_cnt_q + 27'd1;
        if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (sig_rise) begin
          edge_cnt_d = '0;
          state_d    = S_GATE;
        end
      end
      S_GATE: begin
        if (!mode_q) begin
          if (gate_cnt_q == '0) state_d = S_LATCH;
          else                  gate_cnt_d = gate_cnt_q - 27'd1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 27'd1;
          // Nth edge outranks a coincident timeout.
          if (sig_rise && (edge_cnt_q == edge_last)) begin
            state_d = S_LATCH;
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else if (sig_rise) begin
            edge_cnt_d = edge_cnt_q + 7'd1;
          end
        end
      end
      S_LATCH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they align with state_q.
    cnt_clr_d = (state_d == S_CLEAR);
    gate_en_d = (state_d == S_GATE);
    latch_d   = (state_d == S_LATCH);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_ARM) ||
                (state_d == S_GATE)  || (state_d == S_LATCH);
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      fsel_q     <= '0;
      tsel_q     <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      clk_wait_q <= 7'b0000001;
      cnt_clr_q  <= 1'b0;
      gate_en_q  <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fsel_q     <= fsel_d;
      tsel_q     <= tsel_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      clk_wait_q <= clk_wait_d;
      cnt_clr_q  <= cnt_clr_d;
      gate_en_q  <= gate_en_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cnt_clr  = cnt_clr_q;
  assign gate_en  = gate_en_q;
  assign latch    = latch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign cfg_err  = cfg_err_q;
  assign clk_wait = clk_wait_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Scoreboard bench for gate_ctrl: stimulus queues expected measurement
// records, a negedge monitor builds observed records and compares on done/cfg_err.
module tb_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       measure_mode = 1'b0;
  logic [1:0] f_sel = 2'b00;
  logic [1:0] t_sel = 2'b00;
  logic       sig_rise = 1'b0;
  logic       cnt_clr, gate_en, latch, busy, done, timeout, cfg_err;
  logic [6:0] clk_wait;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    bit         cfg;
    bit         abort;
    logic [6:0] cw;
    int         clr_cyc;
    int         gate_off;
    int         gate_len;
    int         latch_n;
    int         tmo_n;
    int         done_off;
  } exp_t;

  exp_t sb[$];

  gate_ctrl #(
    .F_GATE0(4), .F_GATE1(8), .F_GATE2(12), .F_GATE3(16), .T_TIMEOUT(50)
  ) dut (
    .CLK_50(clk), .RST(rst), .start(start), .measure_mode(measure_mode),
    .F_sel(f_sel), .T_sel(t_sel), .sig_rise(sig_rise),
    .cnt_clr(cnt_clr), .gate_en(gate_en), .latch(latch), .busy(busy),
    .done(done), .timeout(timeout), .cfg_err(cfg_err), .clk_wait(clk_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit cfg, input bit abort, input logic [6:0] cw,
                              input int goff, input int glen, input int latch_n,
                              input int tmo_n, input int done_off);
    exp_t e;
    e.cfg = cfg; e.abort = abort; e.cw = cw; e.clr_cyc = 0;
    e.gate_off = goff; e.gate_len = glen; e.latch_n = latch_n;
    e.tmo_n = tmo_n; e.done_off = done_off;
    return e;
  endfunction

  function automatic bit pulse_at(input int i, input int first, input int spacing,
                                  input int count, input int xtra);
    if (i == xtra) return 1'b1;
    if (count > 0 && i >= first && ((i - first) % spacing) == 0 &&
        ((i - first) / spacing) < count) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: observed record built between cnt_clr and done.
  bit         mon_open = 1'b0;
  int         m_clr, m_goff, m_glen, m_latch, m_tmo;
  logic [6:0] m_cw;
  exp_t       me;

  always @(negedge clk) begin
    if (rst) begin
      if (mon_open) begin
        me = sb.pop_front();
        chk("abort_expected", int'(me.abort), 1);
        mon_open = 1'b0;
      end
    end else begin
      if (cnt_clr) begin
        if (mon_open) chk("extra_clear", 1, 0);
        else if (sb.size() == 0) chk("unexpected_clear", 1, 0);
        else if (sb[0].cfg) chk("clear_instead_of_cfg_err", 1, 0);
        else begin
          mon_open = 1'b1;
          m_clr = cyc; m_cw = clk_wait;
          m_goff = 0; m_glen = 0; m_latch = 0; m_tmo = 0;
        end
      end
      if (mon_open) begin
        if (gate_en) begin
          if (m_glen == 0) m_goff = cyc - m_clr;
          m_glen++;
        end
        if (latch)   m_latch++;
        if (timeout) m_tmo++;
        if (done) begin
          me = sb.pop_front();
          chk("aborted_record_completed", int'(me.abort), 0);
          chk("clk_wait", int'(m_cw), int'(me.cw));
          chk("clr_cycle", m_clr, me.clr_cyc);
          chk("gate_first_offset", m_goff, me.gate_off);
          chk("gate_len", m_glen, me.gate_len);
          chk("latch_count", m_latch, me.latch_n);
          chk("timeout_count", m_tmo, me.tmo_n);
          chk("done_offset", cyc - m_clr, me.done_off);
          chk("busy_at_done", int'(busy), 0);
          mon_open = 1'b0;
        end
      end else if (gate_en || latch || done || timeout) begin
        chk("stray_strobe", 1, 0);
      end
      if (cfg_err) begin
        if (sb.size() == 0 || !sb[0].cfg) chk("unexpected_cfg_err", 1, 0);
        else begin
          me = sb.pop_front();
          chk("cfg_err_cycle", cyc, me.clr_cyc);
          chk("cfg_err_clk_wait", int'(clk_wait), int'(me.cw));
          chk("cfg_err_busy", int'(busy), 0);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, int'({cnt_clr, gate_en, latch, busy, done, timeout, cfg_err}), 0);
  endtask

  task automatic run_meas(input bit mode, input logic [1:0] fs, input logic [1:0] ts,
                          input int first, input int spacing, input int count,
                          input int xtra, input int len, input int restart_at,
                          input exp_t e);
    measure_mode = mode; f_sel = fs; t_sel = ts; start = 1'b1;
    e.clr_cyc = cyc + 1;
    sb.push_back(e);
    nxt();
    start = 1'b0;
    measure_mode = ~mode; f_sel = ~fs; t_sel = ~ts;
    for (int i = 1; i <= len; i++) begin
      sig_rise = pulse_at(i, first, spacing, count, xtra);
      start = (i == restart_at);
      nxt();
    end
    sig_rise = 1'b0; start = 1'b0;
    measure_mode = 1'b0; f_sel = 2'b00; t_sel = 2'b00;
    nxt(); nxt();
  endtask

  initial begin
    exp_t e;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_quiet("reset_strobes");
    chk("reset_clk_wait", int'(clk_wait), 1);
    rst = 1'b0; start = 1'b0;
    nxt();
    chk_quiet("post_reset_idle");

    // Frequency ranges; start during DONE of the first must be ignored.
    run_meas(0, 2'b00, 2'b00, 0, 1, 0, 0, 10, 7, mk(0, 0, 7'b0000001, 1, 4, 1, 0, 6));
    run_meas(0, 2'b11, 2'b00, 0, 1, 0, 0, 22, 0, mk(0, 0, 7'b0001000, 1, 16, 1, 0, 18));
    run_meas(0, 2'b01, 2'b00, 0, 1, 0, 0, 14, 0, mk(0, 0, 7'b0000010, 1, 8, 1, 0, 10));
    run_meas(0, 2'b10, 2'b00, 0, 1, 0, 0, 18, 0, mk(0, 0, 7'b0000100, 1, 12, 1, 0, 14));

    // Period T_sel=01: 11 pulses 3 cycles apart.
    run_meas(1, 2'b00, 2'b01, 2, 3, 11, 0, 36, 0, mk(0, 0, 7'b0100000, 2, 30, 1, 0, 33));

    // Invalid config: one cfg_err, clk_wait keeps previous range.
    measure_mode = 1'b1; t_sel = 2'b11; start = 1'b1;
    e = mk(1, 0, 7'b0100000, 0, 0, 0, 0, 0);
    e.clr_cyc = cyc + 1;
    sb.push_back(e);
    nxt();
    start = 1'b0; measure_mode = 1'b0; t_sel = 2'b00;
    repeat (3) begin
      nxt();
      chk("cfg_err_stays_idle", int'(busy), 0);
    end

    // Period T_sel=00 with no edges: timeout 50 cycles after ARM entry.
    run_meas(1, 2'b00, 2'b00, 0, 1, 0, 0, 55, 0, mk(0, 0, 7'b0010000, 0, 0, 0, 1, 51));
    // Edge during CLEAR ignored; edges at 3 and 5 bound the window.
    run_meas(1, 2'b00, 2'b00, 3, 2, 2, 1, 10, 0, mk(0, 0, 7'b0010000, 3, 2, 1, 0, 6));
    // Closing edge coincides with timeout: completion wins.
    run_meas(1, 2'b00, 2'b00, 2, 1, 1, 51, 56, 0, mk(0, 0, 7'b0010000, 2, 49, 1, 0, 52));
    // Closing edge one cycle too late: timeout, late edge in DONE ignored.
    run_meas(1, 2'b00, 2'b00, 2, 1, 1, 52, 56, 0, mk(0, 0, 7'b0010000, 2, 49, 0, 1, 51));
    // T_sel=10 needs 100 edges; continuous edges still time out.
    run_meas(1, 2'b00, 2'b10, 2, 1, 60, 0, 64, 0, mk(0, 0, 7'b1000000, 2, 49, 0, 1, 51));

    // Reset mid-GATE with start held throughout.
    measure_mode = 1'b0; f_sel = 2'b11; start = 1'b1;
    e = mk(0, 1, 7'b0001000, 1, 16, 1, 0, 18);
    e.clr_cyc = cyc + 1;
    sb.push_back(e);
    nxt();
    repeat (5) nxt();
    chk("gate_open_before_reset", int'(gate_en), 1);
    rst = 1'b1;
    nxt();
    chk_quiet("reset_mid_gate");
    chk("reset_mid_gate_clk_wait", int'(clk_wait), 1);
    nxt();
    chk_quiet("reset_dominates_start");
    rst = 1'b0; start = 1'b0; f_sel = 2'b00;
    repeat (5) begin
      nxt();
      chk_quiet("after_abort_idle");
    end

    repeat (4) nxt();
    chk("scoreboard_drained", sb.size(), 0);
    chk("monitor_closed", int'(mon_open), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
